// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: streams the camera frame buffer into the UART transmitter.
// Each VS rising edge starts one frame: pre-guard, then per byte
// READ/LOAD/SEND/WAIT_TX/GAP, then post-guard, then back to IDLE.
// Each byte waits on transmitter busy rather than a fixed cycle budget.
// Optional build macro FRAME_TX_HEADER_EN sends HEADER_BYTE ahead of the RAM bytes.
//
// state      | meaning
// IDLE       | armed, waiting for a VS rising edge
// PRE_GUARD  | GUARD_CYCLES+1 idle cycles before the frame
// HEADER     | load HEADER_BYTE (FRAME_TX_HEADER_EN only)
// READ       | RAM read strobe at the current address
// LOAD       | capture RAM data into the Tx data register
// SEND       | one-cycle transmitter start pulse
// WAIT_TX    | wait for busy to fall (first cycle ignores busy)
// GAP        | GAP_CYCLES+1 idle cycles, then next byte or post-guard
// POST_GUARD | GUARD_CYCLES+1 idle cycles before re-arming
module frame_tx_scheduler #(
  parameter int         BYTES_PER_FRAME = 9216,
  parameter int         ADDR_W          = 15,
  parameter int         GUARD_CYCLES    = 62500000,
  parameter int         GUARD_W         = 26,
  parameter int         GAP_CYCLES      = 1085,
  parameter logic [7:0] HEADER_BYTE     = 8'hA5
) (
  input  logic              Clk,
  input  logic              i_Reset,
  input  logic              i_VS,
  input  logic [7:0]        i_RAM_Data,
  input  logic              i_Tx_Busy,
  output logic              o_Read_Enable,
  output logic [ADDR_W-1:0] o_Read_Address,
  output logic [7:0]        o_Tx_Data,
  output logic              o_Tx_Start,
  output logic              o_Frame_Indicator,
  output logic [7:0]        o_Dropped
);

  localparam logic [GUARD_W-1:0] GUARD_TC  = GUARD_W'(GUARD_CYCLES);
  localparam logic [GUARD_W-1:0] GAP_TC    = GUARD_W'(GAP_CYCLES);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(BYTES_PER_FRAME - 1);

  typedef enum logic [3:0] {
    IDLE,
    PRE_GUARD,
    READ,
    LOAD,
    SEND,
    WAIT_TX,
    GAP,
    POST_GUARD
`ifdef FRAME_TX_HEADER_EN
    , HEADER
`endif
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               vs_meta;
  logic               vs_sync;
  logic               vs_prev;
  logic               vs_rise;
  logic [GUARD_W-1:0] cnt;
  logic [ADDR_W-1:0]  addr;
  logic [7:0]         tx_data;
  logic [7:0]         dropped;
  logic               gap_done;
  logic               last_byte;

`ifdef FRAME_TX_HEADER_EN
  logic hdr_phase;

  // Marks the GAP that follows the header so the address is not advanced
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset)              hdr_phase <= 1'b0;
    else if (state == HEADER) hdr_phase <= 1'b1;
    else if (gap_done)        hdr_phase <= 1'b0;
  end

  assign last_byte = (addr == LAST_ADDR) && !hdr_phase;
`else
  // Header value has no use when the header is not sent
  logic [7:0] unused_header;
  assign unused_header = HEADER_BYTE;
  assign last_byte     = (addr == LAST_ADDR);
`endif

  assign gap_done = (state == GAP) && (cnt == GAP_TC);
  assign vs_rise  = vs_sync & ~vs_prev;

  // Two-flop synchronizer for VS plus the previous-value register for edge detect
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) begin
      vs_meta <= 1'b0;
      vs_sync <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      vs_meta <= i_VS;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  // State register
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode and state-decoded strobes
  always_comb begin
    state_next        = state;
    o_Read_Enable     = 1'b0;
    o_Tx_Start        = 1'b0;
    o_Frame_Indicator = 1'b0;
    case (state)
      IDLE: begin
        o_Frame_Indicator = 1'b1;
        if (vs_rise) state_next = PRE_GUARD;
      end
      PRE_GUARD: begin
        if (cnt == GUARD_TC) begin
`ifdef FRAME_TX_HEADER_EN
          state_next = HEADER;
`else
          state_next = READ;
`endif
        end
      end
      READ: begin
        o_Read_Enable = 1'b1;
        state_next    = LOAD;
      end
      LOAD: state_next = SEND;
      SEND: begin
        o_Tx_Start = 1'b1;
        state_next = WAIT_TX;
      end
      // cnt is 0 only in the first WAIT_TX cycle, where busy may not be up yet
      WAIT_TX: if (cnt != '0 && !i_Tx_Busy) state_next = GAP;
      GAP: if (gap_done) state_next = last_byte ? POST_GUARD : READ;
      POST_GUARD: if (cnt == GUARD_TC) state_next = IDLE;
`ifdef FRAME_TX_HEADER_EN
      HEADER: state_next = SEND;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Shared interval counter: cleared on every state change, saturates instead of wrapping
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset)                  cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (cnt != '1)           cnt <= cnt + 1'b1;
  end

  // Read address advances at the end of each GAP and returns to 0 after the last byte
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset) begin
      addr <= '0;
    end else if (gap_done) begin
      if (last_byte)      addr <= '0;
`ifdef FRAME_TX_HEADER_EN
      else if (hdr_phase) addr <= addr;
`endif
      else                addr <= addr + 1'b1;
    end
  end

  // Tx data register, held from SEND until the next load
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset)            tx_data <= 8'h00;
    else if (state == LOAD) tx_data <= i_RAM_Data;
`ifdef FRAME_TX_HEADER_EN
    else if (state == HEADER) tx_data <= HEADER_BYTE;
`endif
  end

  // Saturating count of VS edges that arrive while not armed
  always_ff @(posedge Clk or posedge i_Reset) begin
    if (i_Reset)
      dropped <= 8'h00;
    else if (vs_rise && state != IDLE && dropped != 8'hFF)
      dropped <= dropped + 8'h01;
  end

  assign o_Read_Address = addr;
  assign o_Tx_Data      = tx_data;
  assign o_Dropped      = dropped;

endmodule
